// File: rtl/vram_pkg.sv
// Shared video-RAM definitions.
//   VRAM_ADDR_W / PIXEL_W : word-address and RGB565 pixel widths, also used by
//                           the video_ram and image_rom wrappers.
//   state_t               : write-arbiter ownership state.
package vram_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int PIXEL_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

endpackage

// File: rtl/vram_rr_pick.sv
// Round-robin chooser for the two VRAM write requesters (combinational).
//   req0_valid, req1_valid : requester valids
//   rr_ptr                 : 0 = favour requester 0, 1 = favour requester 1
//   pick_any               : at least one requester is valid
//   pick_one               : chosen owner is requester 1 (else requester 0)
module vram_rr_pick (
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic rr_ptr,
  output logic pick_any,
  output logic pick_one
);

  always_comb begin
    pick_any = req0_valid | req1_valid;
    // Requester 1 wins when it is alone, or when both ask and it is favoured.
    pick_one = req1_valid & (~req0_valid | rr_ptr);
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the video RAM write port between the image-ROM loader (requester 0)
// and the pattern/fill engine or host (requester 1). Round-robin with bounded
// bursts, plus an optional vertical-blanking gate.
//   clk, reset                : write clock, synchronous active-high reset
//   reqN_valid/addr/data      : requester beat
//   reqN_ready                : beat accepted this cycle
//   vblank, blank_only        : accept only during vblank when blank_only=1
//   write_ce/ad/data          : registered video RAM write port
//   grant                     : one-hot owner, 00 = idle
//   busy                      : write pending or owner present
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W    = VRAM_ADDR_W,
  parameter int DATA_W    = PIXEL_W,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              vblank,
  input  logic              blank_only,
  output logic              write_ce,
  output logic [ADDR_W-1:0] write_ad,
  output logic [DATA_W-1:0] write_data,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t           state;
  logic             rr_ptr;
  logic [CNT_W-1:0] count;

  logic   gate_open;
  logic   xfer0, xfer1, xfer;
  logic   own_valid, oth_valid;
  state_t other_state;
  logic   other_ptr;
  logic   pick_any, pick_one;

  vram_rr_pick u_pick (
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .rr_ptr     (rr_ptr),
    .pick_any   (pick_any),
    .pick_one   (pick_one)
  );

  always_comb begin
    gate_open   = ~blank_only | vblank;
    req0_ready  = (state == GRANT0) & gate_open;
    req1_ready  = (state == GRANT1) & gate_open;
    xfer0       = req0_valid & req0_ready;
    xfer1       = req1_valid & req1_ready;
    xfer        = xfer0 | xfer1;
    grant       = {state == GRANT1, state == GRANT0};
    busy        = write_ce | (|grant);
    // Owner-relative view so both GRANT states share one set of rules.
    own_valid   = (state == GRANT1) ? req1_valid : req0_valid;
    oth_valid   = (state == GRANT1) ? req0_valid : req1_valid;
    other_state = (state == GRANT1) ? GRANT0 : GRANT1;
    other_ptr   = (state == GRANT0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      count      <= '0;
      write_ce   <= 1'b0;
      write_ad   <= '0;
      write_data <= '0;
    end else begin
      write_ce <= xfer;
      if (xfer0) begin
        write_ad   <= req0_addr;
        write_data <= req0_data;
      end else if (xfer1) begin
        write_ad   <= req1_addr;
        write_data <= req1_data;
      end

      case (state)
        IDLE: begin
          if (pick_any) state <= pick_one ? GRANT1 : GRANT0;
        end
        GRANT0, GRANT1: begin
          if (xfer) begin
            if (count == LAST && oth_valid) begin
              state  <= other_state;
              count  <= '0;
              rr_ptr <= other_ptr;
            end else if (count != LAST) begin
              count <= count + CNT_W'(1);
            end
          end else if (!own_valid) begin
            count <= '0;
            if (oth_valid) begin
              state  <= other_state;
              rr_ptr <= other_ptr;
            end else begin
              state <= IDLE;
            end
          end
          // Owner still valid but gate closed: hold state and count.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
